// File: rtl/yapay_zeka_carp_topla_birimi_if.sv
// Result write-back channel of the multiply-accumulate unit.
// The unit drives result and valid; the write-back stage drives ready.
interface yapay_zeka_carp_topla_birimi_if;
    logic [31:0] sonuc_o;
    logic        sonuc_gecerli_o;
    logic        sonuc_hazir_i;

    modport master (
        output sonuc_o,
        output sonuc_gecerli_o,
        input  sonuc_hazir_i
    );

    modport slave (
        input  sonuc_o,
        input  sonuc_gecerli_o,
        output sonuc_hazir_i
    );
endinterface

// File: rtl/yapay_zeka_carp_topla_birimi.sv
// Dot product of N data/filter buffer element pairs, accumulated onto a bias.
// Define YAPAY_ZEKA_DOYMA_EN for saturating product and accumulation.
module yapay_zeka_carp_topla_birimi #(
    parameter int ELEMAN_MAKS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        baslat_i,
    input  logic [4:0]  eleman_sayisi_i,
    input  logic [31:0] sapma_i,
    input  logic [31:0] veri_deger_i,
    input  logic [31:0] filtre_deger_i,
    output logic        veri_oku_en_o,
    output logic        filtre_oku_en_o,
    output logic        mesgul_o,
    yapay_zeka_carp_topla_birimi_if.master sonuc_if
);

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        OKU    = 2'd1,
        BOSALT = 2'd2,
        SONUC  = 2'd3
    } durum_e;

    localparam logic [4:0] N_MAKS = 5'(ELEMAN_MAKS);

`ifdef YAPAY_ZEKA_DOYMA_EN
    function automatic logic [31:0] carp(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] tam;
        tam = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        if (!tam[63] && (tam[62:31] != 32'h0)) begin
            return 32'h7FFF_FFFF;
        end else if (tam[63] && (tam[62:31] != 32'hFFFF_FFFF)) begin
            return 32'h8000_0000;
        end else begin
            return tam[31:0];
        end
    endfunction

    function automatic logic [31:0] topla(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            return s[31:0];
        end
    endfunction
`else
    function automatic logic [31:0] carp(input logic [31:0] a,
                                         input logic [31:0] b);
        return a * b;
    endfunction

    function automatic logic [31:0] topla(input logic [31:0] a,
                                          input logic [31:0] b);
        return a + b;
    endfunction
`endif

    durum_e      durum_q, durum_d;
    logic [4:0]  n_q, n_d;
    logic [4:0]  sayac_q, sayac_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] p_q, p_d;
    logic        pv_q, pv_d;
    logic [31:0] sonuc_q, sonuc_d;

    // Next-state, datapath updates and outputs
    always_comb begin
        durum_d = durum_q;
        n_d     = n_q;
        sayac_d = sayac_q;
        acc_d   = acc_q;
        p_d     = p_q;
        pv_d    = pv_q;
        sonuc_d = sonuc_q;

        veri_oku_en_o            = 1'b0;
        filtre_oku_en_o          = 1'b0;
        mesgul_o                 = (durum_q != BOSTA);
        sonuc_if.sonuc_gecerli_o = 1'b0;

        unique case (durum_q)
            BOSTA: begin
                if (baslat_i) begin
                    n_d     = (eleman_sayisi_i > N_MAKS) ? N_MAKS
                                                         : eleman_sayisi_i;
                    acc_d   = sapma_i;
                    pv_d    = 1'b0;
                    sayac_d = 5'd0;
                    durum_d = (n_d == 5'd0) ? BOSALT : OKU;
                end
            end
            OKU: begin
                veri_oku_en_o   = 1'b1;
                filtre_oku_en_o = 1'b1;
                p_d             = carp(veri_deger_i, filtre_deger_i);
                pv_d            = 1'b1;
                if (pv_q) begin
                    acc_d = topla(acc_q, p_q);
                end
                sayac_d = sayac_q + 5'd1;
                if (sayac_d == n_q) begin
                    durum_d = BOSALT;
                end
            end
            BOSALT: begin
                if (pv_q) begin
                    acc_d = topla(acc_q, p_q);
                end
                pv_d    = 1'b0;
                sonuc_d = acc_d;
                durum_d = SONUC;
            end
            SONUC: begin
                sonuc_if.sonuc_gecerli_o = 1'b1;
                if (sonuc_if.sonuc_hazir_i) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
            n_q     <= 5'd0;
            sayac_q <= 5'd0;
            acc_q   <= 32'd0;
            p_q     <= 32'd0;
            pv_q    <= 1'b0;
            sonuc_q <= 32'd0;
        end else begin
            durum_q <= durum_d;
            n_q     <= n_d;
            sayac_q <= sayac_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            pv_q    <= pv_d;
            sonuc_q <= sonuc_d;
        end
    end

    assign sonuc_if.sonuc_o = sonuc_q;

endmodule

// File: tb/tb_yapay_zeka_carp_topla_birimi.sv
// Self-checking bench for the dot product unit with modelled
// data/filter buffers and a plain-arithmetic reference model.
module tb_yapay_zeka_carp_topla_birimi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        baslat_i;
    logic [4:0]  eleman_sayisi_i;
    logic [31:0] sapma_i;
    logic [31:0] veri_deger_i;
    logic [31:0] filtre_deger_i;
    logic        veri_oku_en_o;
    logic        filtre_oku_en_o;
    logic        mesgul_o;

    yapay_zeka_carp_topla_birimi_if sif();

    yapay_zeka_carp_topla_birimi dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .baslat_i        (baslat_i),
        .eleman_sayisi_i (eleman_sayisi_i),
        .sapma_i         (sapma_i),
        .veri_deger_i    (veri_deger_i),
        .filtre_deger_i  (filtre_deger_i),
        .veri_oku_en_o   (veri_oku_en_o),
        .filtre_oku_en_o (filtre_oku_en_o),
        .mesgul_o        (mesgul_o),
        .sonuc_if        (sif.master)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] veri_mem   [16];
    logic [31:0] filtre_mem [16];
    logic [3:0]  vptr = 4'd0;
    logic [3:0]  fptr = 4'd0;
    int          ven_cnt = 0;
    int          fen_cnt = 0;

    assign veri_deger_i   = veri_mem[vptr];
    assign filtre_deger_i = filtre_mem[fptr];

    // Buffer read pointers advance on each enable; never reset
    always @(posedge clk_i) begin
        if (veri_oku_en_o) begin
            vptr    <= vptr + 4'd1;
            ven_cnt <= ven_cnt + 1;
        end
        if (filtre_oku_en_o) begin
            fptr    <= fptr + 4'd1;
            fen_cnt <= fen_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef YAPAY_ZEKA_DOYMA_EN
    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction
`endif

    // Expected dot product from buffer contents at current pointers
    function automatic logic [31:0] model(input logic [31:0] bias,
                                          input int n);
        longint acc;
        longint p;
        int     k;
        k   = (n > 16) ? 16 : n;
        acc = longint'($signed(bias));
        for (int i = 0; i < k; i++) begin
            p = longint'($signed(veri_mem[4'(vptr + 4'(i))])) *
                longint'($signed(filtre_mem[4'(fptr + 4'(i))]));
`ifdef YAPAY_ZEKA_DOYMA_EN
            acc = sat(acc + sat(p));
`else
            acc = acc + p;
`endif
        end
        return acc[31:0];
    endfunction

    task automatic put(input int i, input logic [31:0] v,
                       input logic [31:0] f);
        veri_mem[4'(vptr + 4'(i))]   = v;
        filtre_mem[4'(fptr + 4'(i))] = f;
    endtask

    // One operation: start, latency, result, enables, hold, release
    task automatic run_op(input string tag, input logic [4:0] n,
                          input logic [31:0] bias, input logic [31:0] exp,
                          input int hold);
        int          k;
        int          lat;
        int          v0;
        int          f0;
        logic [3:0]  vp0;
        logic [31:0] s0;
        k   = (n > 5'd16) ? 16 : int'(n);
        v0  = ven_cnt;
        f0  = fen_cnt;
        vp0 = vptr;
        baslat_i        = 1'b1;
        eleman_sayisi_i = n;
        sapma_i         = bias;
        @(posedge clk_i);
        #1;
        baslat_i = 1'b0;
        sapma_i  = $urandom;
        lat = 1;
        while (!sif.sonuc_gecerli_o && lat < 40) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(k + 2));
        chk({tag, "_result"}, sif.sonuc_o, exp);
        chk({tag, "_ven"}, 32'(ven_cnt - v0), 32'(k));
        chk({tag, "_fen"}, 32'(fen_cnt - f0), 32'(k));
        chk({tag, "_ptr"}, 32'(vptr), 32'(4'(vp0 + 4'(k))));
        s0 = sif.sonuc_o;
        for (int c = 0; c < hold; c++) begin
            baslat_i = c[0];
            @(posedge clk_i);
            #1;
            chk({tag, "_hold_valid"}, 32'(sif.sonuc_gecerli_o), 32'd1);
            chk({tag, "_hold_res"}, sif.sonuc_o, s0);
            chk({tag, "_hold_busy"}, 32'(mesgul_o), 32'd1);
        end
        baslat_i             = 1'b0;
        sif.sonuc_hazir_i    = 1'b1;
        @(posedge clk_i);
        #1;
        sif.sonuc_hazir_i = 1'b0;
        chk({tag, "_idle_busy"}, 32'(mesgul_o), 32'd0);
        chk({tag, "_idle_valid"}, 32'(sif.sonuc_gecerli_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk({tag, "_no_restart"}, 32'(ven_cnt - v0), 32'(k));
    endtask

    initial begin
        logic [31:0] e;
        int          n;
        rst_i             = 1'b1;
        baslat_i          = 1'b0;
        eleman_sayisi_i   = 5'd0;
        sapma_i           = 32'd0;
        sif.sonuc_hazir_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            veri_mem[i]   = 32'd0;
            filtre_mem[i] = 32'd0;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_sonuc", sif.sonuc_o, 32'd0);
        chk("rst_valid", 32'(sif.sonuc_gecerli_o), 32'd0);
        chk("rst_busy", 32'(mesgul_o), 32'd0);
        chk("rst_ven", 32'(veri_oku_en_o), 32'd0);
        chk("rst_fen", 32'(filtre_oku_en_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 4; i++) put(i, 32'(i + 1), 32'(i + 5));
        run_op("basic", 5'd4, 32'd10, 32'd80, 0);

        run_op("empty", 5'd0, -32'sd7, 32'hFFFF_FFF9, 0);

        for (int i = 0; i < 3; i++) put(i, 32'(i + 2), 32'd3);
        run_op("hold", 5'd3, 32'd1, 32'd28, 5);

        put(0, 32'h7FFF_FFFF, 32'd2);
        put(1, 32'd1, 32'd1);
`ifdef YAPAY_ZEKA_DOYMA_EN
        run_op("ovf", 5'd2, 32'd0, 32'h7FFF_FFFF, 0);
`else
        run_op("ovf", 5'd2, 32'd0, 32'hFFFF_FFFF, 0);
`endif

        for (int i = 0; i < 16; i++) put(i, 32'hFFFF_FFFF, 32'd3);
        run_op("full", 5'd16, 32'd0, 32'hFFFF_FFD0, 0);
        run_op("clamp", 5'd20, 32'd0, 32'hFFFF_FFD0, 0);

        n = ven_cnt;
        baslat_i        = 1'b1;
        eleman_sayisi_i = 5'd8;
        sapma_i         = 32'd5;
        @(posedge clk_i);
        #1;
        baslat_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(mesgul_o), 32'd0);
        chk("mid_rst_ven", 32'(veri_oku_en_o), 32'd0);
        chk("mid_rst_fen", 32'(filtre_oku_en_o), 32'd0);
        chk("mid_rst_valid", 32'(sif.sonuc_gecerli_o), 32'd0);
        chk("mid_rst_sonuc", sif.sonuc_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("mid_rst_reads", 32'(ven_cnt - n), 32'd1);
        put(0, 32'd3, 32'd4);
        run_op("after_rst", 5'd1, 32'd0, 32'd12, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                if (r[0]) put(i, 32'($signed($urandom_range(0, 40)) - 20),
                              32'($signed($urandom_range(0, 40)) - 20));
                else      put(i, $urandom, $urandom);
            end
            n = (r == 7) ? 17 : int'($urandom_range(0, 16));
            sapma_i = $urandom;
            e = model(sapma_i, n);
            run_op($sformatf("rnd%0d", r), 5'(n), sapma_i, e, r % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yapay_zeka_carp_topla_birimi.md
# yapay_zeka_carp_topla_birimi

Downstream consumer of the AI unit's two 16×32 buffers: the data buffer and the filter buffer. Sequentially drains N element pairs from both buffers in lockstep and accumulates their signed products onto a bias value to form a dot product. Returns the 32-bit result to the X-instruction write-back path over a valid/ready handshake. Holds `mesgul_o` while working so the pipeline can stall.

## Interface
- `ELEMAN_MAKS`, 16, buffer depth; maximum element count per operation.
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `baslat_i`  in  1  start request; sampled only in BOSTA.
- `eleman_sayisi_i`  in  5  element count N, 0..16. Values above 16 are clamped to 16.
- `sapma_i`  in  32  signed bias; the initial accumulator value.
- `veri_deger_i`  in  32  signed element at the data buffer's current read pointer (combinational).
- `filtre_deger_i`  in  32  signed element at the filter buffer's current read pointer (combinational).
- `veri_oku_en_o`  out  1  advances the data buffer read pointer at the next edge.
- `filtre_oku_en_o`  out  1  advances the filter buffer read pointer at the next edge.
- `sonuc_o`  out  32  dot product result.
- `sonuc_gecerli_o`  out  1  result valid.
- `sonuc_hazir_i`  in  1  consumer ready.
- `mesgul_o`  out  1  high whenever the state is not BOSTA.

## Operation
- **State machine:** BOSTA → OKU → BOSALT → SONUC → BOSTA.
- **BOSTA**
  - When `baslat_i` is high: latch N (clamped), load the accumulator with `sapma_i`, clear the product-valid flag and the counter.
  - If N=0, go to BOSALT; otherwise go to OKU.
- **OKU**
  - `veri_oku_en_o` and `filtre_oku_en_o` are both high, combinationally equal to (state==OKU).
  - Each cycle: register p = veri×filtre (signed), and set the product-valid flag.
  - Each cycle: if the flag was already set, add the previous p into the accumulator.
  - The counter increments; after N cycles, go to BOSALT.
- **BOSALT**
  - One cycle. Adds the final pending p if the flag is set, then clears the flag.
  - Copies the accumulator into `sonuc_o` at the next edge and goes to SONUC.
- **SONUC**
  - `sonuc_gecerli_o` is high. `sonuc_o` is stable.
  - Leaves to BOSTA on the cycle where `sonuc_hazir_i` is high.
  - A `baslat_i` arriving in the same cycle is ignored; it is only seen in BOSTA.
- **Arithmetic (default):** p is the low 32 bits of the signed product. Accumulation is modulo 2^32 (RISC-V `mul` semantics).
- **Start handling:** `baslat_i` while busy is ignored. The issuing stage must hold the instruction until `mesgul_o` falls.
- **Buffer pointers:** this block never resets them. Exactly N read enables are issued per operation, so the buffer pointers advance by N (mod 16).

## Timing
- **Reset values:** `sonuc_o`=0, `sonuc_gecerli_o`=0, `mesgul_o`=0, both read enables 0; state BOSTA, accumulator 0, flag 0.
- **Cycle numbering:** the start accepted at edge 0.
  - N≥1: cycles 1..N are OKU, cycle N+1 is BOSALT, and `sonuc_gecerli_o` is high from cycle N+2.
  - N=0: cycle 1 is BOSALT and the result equals `sapma_i` from cycle 2.
  - Latency from start to valid is N+2 cycles.
- **Read enables:** high for exactly N consecutive cycles. Data is consumed in the same cycle that enable is high, then the pointer advances.
- **Mid-operation reset:** asynchronous return to BOSTA. All outputs drop immediately and any partial result is discarded.
- **Back-to-back:** the earliest next start is the cycle after the handshake completes (state BOSTA).

## Configuration
- `YAPAY_ZEKA_DOYMA_EN` defined:
  - p is the full 64-bit signed product, saturated to [−2^31, 2^31−1].
  - Each accumulate saturates to the same range instead of wrapping.
  - Timing is unchanged.
- Not defined: wrap-around arithmetic as described in Operation.

## Test plan
- **Basic dot product:** N=4, bias 10, data {1,2,3,4}, filter {5,6,7,8} → `sonuc_o`=80; valid at cycle 6; exactly 4 read-enable cycles.
- **Empty operation:** N=0, bias −7 → `sonuc_o`=0xFFFFFFF9 valid at cycle 2; no read enables.
- **Handshake hold:** `sonuc_hazir_i` held low 5 cycles → valid and result stable, `mesgul_o` high throughout; `baslat_i` pulses in that window are ignored; release → BOSTA one cycle later.
- **Overflow:** N=2, bias 0, data {0x7FFFFFFF, 1}, filter {2, 1}.
  - Default → 0xFFFFFFFF (wrap).
  - With `YAPAY_ZEKA_DOYMA_EN` → 0x7FFFFFFF.
- **Full depth and negatives:** N=16, bias 0, data = −1 everywhere, filter = 3 everywhere → −48 (0xFFFFFFD0); 16 read enables. N=20 is clamped to 16 with the same result.
- **Reset mid-operation:** assert `rst_i` in OKU cycle 2 of an N=8 operation → outputs 0 immediately; the next operation with N=1, 3×4, bias 0 → 12.
